// File: rtl/me_pkg.sv
// Shared constants, FSM encoding and beat bundle for the
// motion-estimation current-frame feed path.
package me_pkg;
  localparam int PIXEL = 8;
  localparam int X = 32;
  localparam int Y = 32;
  localparam int BEATS_PER_ROW = X / 2;
  localparam int BEATS_PER_CB = X * Y / 2;
  localparam int BEAT_W = $clog2(BEATS_PER_ROW);
  localparam int ROW_W = $clog2(Y);

  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t FETCH  = 3'd1;
  localparam state_t DRAIN  = 3'd2;
  localparam state_t COMMIT = 3'd3;
  localparam state_t FIN    = 3'd4;

  typedef struct packed {
    logic               vld;
    logic [2*PIXEL-1:0] data;
  } beat_t;
endpackage

// File: rtl/curr_rd_pipe.sv
// Two-stage valid/data pipe from SRAM read strobe to array beat.
// Stage 1 tracks the in-flight read, stage 2 registers the data.
module curr_rd_pipe
  import me_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [2*PIXEL-1:0] rd_data,
  output logic [2*PIXEL-1:0] beat_data,
  output logic               beat_vld,
  output logic               empty
);

  logic  s1_vld;
  beat_t s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2     <= '0;
    end else begin
      s1_vld <= rd_en;
      s2.vld <= s1_vld;
      if (s1_vld) s2.data <= rd_data;
    end
  end

  assign beat_data = s2.data;
  assign beat_vld  = s2.vld;
  // No read left in flight once stage 1 is clear
  assign empty     = !s1_vld;

endmodule

// File: rtl/array_curr_feeder.sv
// Streams 1..8 current coding blocks from SRAM into the ME PE
// array as 2-pixel beats, committing each block with change_curr.
module array_curr_feeder
  import me_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NCB_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [NCB_W-1:0]   cb_count,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [2*PIXEL-1:0] mem_rd_data,
  output logic [2*PIXEL-1:0] current_2pixels,
  output logic               in_curr_enable,
  output logic               change_curr,
  output logic [NCB_W-1:0]   CB_select
);

  localparam int OFF_W = NCB_W + ROW_W + BEAT_W;
  localparam logic [BEAT_W-1:0] BEAT_LAST =
    BEAT_W'(BEATS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(Y - 1);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [NCB_W-1:0]  cnt_q;
  logic [NCB_W-1:0]  cb_idx;
  logic [ROW_W-1:0]  row;
  logic [BEAT_W-1:0] beat;
  logic              rd_go;
  logic              last_rd;
  logic              pipe_empty;
  logic [OFF_W-1:0]  off;

  assign rd_go   = (state == FETCH) && !hold;
  assign last_rd = (row == ROW_LAST) && (beat == BEAT_LAST);
  // Power-of-two block geometry turns the offset into a concat
  assign off     = {cb_idx, row, beat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      cnt_q  <= '0;
      cb_idx <= '0;
      row    <= '0;
      beat   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            cnt_q  <= cb_count;
            cb_idx <= '0;
            row    <= '0;
            beat   <= '0;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (!hold) begin
            if (beat == BEAT_LAST) begin
              beat <= '0;
              row  <= last_rd ? '0 : row + ROW_W'(1);
            end else begin
              beat <= beat + BEAT_W'(1);
            end
            if (last_rd) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_empty) state <= COMMIT;
        end
        COMMIT: begin
          if (cb_idx == cnt_q) begin
            state <= FIN;
          end else begin
            cb_idx <= cb_idx + NCB_W'(1);
            state  <= FETCH;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  curr_rd_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_go),
    .rd_data   (mem_rd_data),
    .beat_data (current_2pixels),
    .beat_vld  (in_curr_enable),
    .empty     (pipe_empty)
  );

  assign mem_rd_en   = rd_go;
  assign mem_addr    = rd_go ? base_q + ADDR_W'(off) : '0;
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign change_curr = (state == COMMIT);
  assign CB_select   = cb_idx;

endmodule
